// File: rtl/jtkiwi_rom_pkg.sv
// Shared definitions for the CPU ROM responder: fetch FSM states and
// cache line geometry (one line of four bytes filled by a two-word burst).
package jtkiwi_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int LINE_BYTES  = 4;
    localparam int BURST_WORDS = 2;

endpackage

// File: rtl/jtkiwi_rom_rsp.sv
// CPU ROM fetch responder with a one-line, four-byte cache.
// Hits are answered combinationally; misses fetch the line through a
// two-word SDRAM burst.
// Optional hit/miss statistics counters: define JTKIWI_ROMRSP_STATS_EN.
module jtkiwi_rom_rsp
    import jtkiwi_rom_pkg::*;
#(
    parameter int AW    = 16,
    parameter int STATS = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rom_cs,
    input  logic [AW-1:0] rom_addr,
    output logic [7:0]    rom_data,
    output logic          rom_ok,
    input  logic          inv,
    output logic [AW-2:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_gnt,
    input  logic          sdram_dst,
    input  logic [15:0]   sdram_din
`ifdef JTKIWI_ROMRSP_STATS_EN
    ,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
`endif
);

    // STATS is reserved; statistics are selected only by the macro.
    if (STATS != 0) begin : g_stats_reserved
        $error("jtkiwi_rom_rsp: STATS is reserved and must be 0");
    end

    localparam logic WLAST = 1'(BURST_WORDS - 1);

    state_t                  state_q;
    logic                    valid_q;
    logic                    inv_seen_q;
    logic [AW-3:0]           tag_q;
    logic [AW-3:0]           ftag_q;
    logic [8*LINE_BYTES-1:0] line_q;
    logic [AW-2:0]           addr_q;
    logic                    req_q;
    logic                    wcnt_q;
    logic                    hit;

    // A hit is only reported while no fetch is in flight.
    assign hit        = rom_cs && valid_q && (tag_q == rom_addr[AW-1:2]) && (state_q == IDLE);
    assign rom_ok     = hit;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    // Little-endian byte select out of the cached line.
    always_comb begin
        rom_data = 8'd0;
        case (rom_addr[1:0])
            2'd0: rom_data = line_q[7:0];
            2'd1: rom_data = line_q[15:8];
            2'd2: rom_data = line_q[23:16];
            2'd3: rom_data = line_q[31:24];
            default: rom_data = 8'd0;
        endcase
    end

    // Fetch FSM: issue the burst on a miss, collect two words, then refresh the tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            inv_seen_q <= 1'b0;
            tag_q      <= '0;
            ftag_q     <= '0;
            line_q     <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            wcnt_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    inv_seen_q <= 1'b0;
                    if (inv) valid_q <= 1'b0;
                    if (rom_cs && !hit && !inv) begin
                        ftag_q  <= rom_addr[AW-1:2];
                        addr_q  <= {rom_addr[AW-1:2], 1'b0};
                        req_q   <= 1'b1;
                        wcnt_q  <= 1'b0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (inv) inv_seen_q <= 1'b1;
                    if (sdram_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (inv) inv_seen_q <= 1'b1;
                    if (sdram_dst) begin
                        line_q[{wcnt_q, 4'd0} +: 16] <= sdram_din;
                        if (wcnt_q == WLAST) begin
                            // An invalidate seen at any point of the burst discards the line.
                            tag_q   <= ftag_q;
                            valid_q <= ~(inv | inv_seen_q);
                            wcnt_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef JTKIWI_ROMRSP_STATS_EN
    logic          cs_prev_q;
    logic [AW-1:0] addr_prev_q;
    logic [15:0]   hit_cnt_q;
    logic [15:0]   miss_cnt_q;
    logic          hit_evt;
    logic          miss_evt;

    // A hit counts once per new request: rom_cs rising or the address moving.
    assign hit_evt  = hit && (!cs_prev_q || (addr_prev_q != rom_addr));
    assign miss_evt = (state_q == IDLE) && rom_cs && !hit && !inv;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Saturating hit/miss counters plus the request history used for edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_prev_q   <= 1'b0;
            addr_prev_q <= '0;
            hit_cnt_q   <= 16'd0;
            miss_cnt_q  <= 16'd0;
        end else begin
            cs_prev_q   <= rom_cs;
            addr_prev_q <= rom_addr;
            if (hit_evt && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
            if (miss_evt && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jtkiwi_rom_rsp.sv
// Directed bench for jtkiwi_rom_rsp with an expected-byte scoreboard.
module tb_jtkiwi_rom_rsp;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rom_cs;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        inv;
    logic [14:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_gnt;
    logic        sdram_dst;
    logic [15:0] sdram_din;
`ifdef JTKIWI_ROMRSP_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    jtkiwi_rom_rsp #(.AW(16), .STATS(0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .inv        (inv),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_gnt  (sdram_gnt),
        .sdram_dst  (sdram_dst),
        .sdram_din  (sdram_din)
`ifdef JTKIWI_ROMRSP_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    // SDRAM content model (word addressed)
    function automatic logic [15:0] memw(input logic [14:0] wa);
        case (wa)
            15'h0080: memw = 16'hBBAA;
            15'h0081: memw = 16'hDDCC;
            default:  memw = {wa[7:0] ^ 8'hA5, wa[7:0]};
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input logic [15:0] a);
        logic [15:0] w;
        w = memw(a[15:1]);
        exp_byte = a[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for rom_ok, then pop the scoreboard and compare the byte.
    task automatic observe(input string tag, input int budget);
        logic [7:0] e;
        int n;
        n = 0;
        @(negedge clk);
        while (!rom_ok && n < budget) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        chk({tag, "_ok"}, 32'(rom_ok), 32'd1);
        chk({tag, "_data"}, 32'(rom_data), 32'(e));
    endtask

    // Answer one burst request; gap>0 adds stray dst in REQ and stray gnt in DATA.
    task automatic serve_burst(input logic [14:0] wa, input int gap);
        int n;
        n = 0;
        @(negedge clk);
        while (!sdram_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(sdram_req), 32'd1);
        if (!sdram_req) return;
        chk("req_addr", 32'(sdram_addr), 32'(wa));
        if (gap > 0) begin
            sdram_dst = 1'b1;
            sdram_din = 16'hDEAD;
            @(negedge clk);
            sdram_dst = 1'b0;
            chk("req_hold", 32'(sdram_req), 32'd1);
        end
        sdram_gnt = 1'b1;
        @(negedge clk);
        sdram_gnt = 1'b0;
        chk("req_drop", 32'(sdram_req), 32'd0);
        for (int w = 0; w < 2; w++) begin
            for (int g = 0; g < gap; g++) begin
                sdram_gnt = (g == 0);
                @(negedge clk);
                sdram_gnt = 1'b0;
                chk("fill_busy_ok", 32'(rom_ok), 32'd0);
            end
            sdram_dst = 1'b1;
            sdram_din = memw(wa + 15'(w));
            @(negedge clk);
            sdram_dst = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] hv[3];
        hv = '{16'h0100, 16'h0101, 16'h0103};
        rstn = 1'b0; rom_cs = 1'b0; rom_addr = 16'h0000; inv = 1'b0;
        sdram_gnt = 1'b0; sdram_dst = 1'b0; sdram_din = 16'h0000;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ok", 32'(rom_ok), 32'd0);
        chk("rst_data", 32'(rom_data), 32'd0);
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        rstn = 1'b1;

        // miss latency with immediate grant and strobes
        tick();
        rom_cs = 1'b1; rom_addr = 16'h0102;
        sb.push_back(exp_byte(16'h0102));
        @(negedge clk);
        chk("lat_t0_ok", 32'(rom_ok), 32'd0);
        chk("lat_t0_req", 32'(sdram_req), 32'd0);
        tick();
        sdram_gnt = 1'b1;
        @(negedge clk);
        chk("lat_t1_req", 32'(sdram_req), 32'd1);
        chk("lat_t1_addr", 32'(sdram_addr), 32'h0080);
        tick();
        sdram_gnt = 1'b0; sdram_dst = 1'b1; sdram_din = 16'hBBAA;
        @(negedge clk);
        chk("lat_t2_req", 32'(sdram_req), 32'd0);
        chk("lat_t2_ok", 32'(rom_ok), 32'd0);
        tick();
        sdram_din = 16'hDDCC;
        @(negedge clk);
        chk("lat_t3_ok", 32'(rom_ok), 32'd0);
        tick();
        sdram_dst = 1'b0;
        observe("lat_t4", 0);

        // same-line hits, zero latency, no request
        for (int i = 0; i < 3; i++) begin
            tick();
            rom_addr = hv[i];
            sb.push_back(exp_byte(hv[i]));
            observe("hit", 0);
            chk("hit_noreq", 32'(sdram_req), 32'd0);
        end

        // invalidate while idle
        tick();
        inv = 1'b1;
        @(negedge clk);
        chk("inv_idle_same", 32'(rom_ok), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("inv_idle_ok", 32'(rom_ok), 32'd0);
            chk("inv_idle_req", 32'(sdram_req), 32'd0);
        end
        inv = 1'b0;
        sb.push_back(exp_byte(16'h0103));
        serve_burst(15'h0080, 1);
        observe("inv_refill", 1);

        // address moves to another line during DATA
        tick();
        rom_addr = 16'h0300;
        tick();
        sdram_gnt = 1'b1;
        tick();
        sdram_gnt = 1'b0; sdram_dst = 1'b1; sdram_din = memw(15'h0180);
        rom_addr = 16'h0200;
        @(negedge clk);
        chk("mv_d0_ok", 32'(rom_ok), 32'd0);
        tick();
        sdram_din = memw(15'h0181);
        @(negedge clk);
        chk("mv_d1_ok", 32'(rom_ok), 32'd0);
        tick();
        sdram_dst = 1'b0;
        @(negedge clk);
        chk("mv_idle_ok", 32'(rom_ok), 32'd0);
        sb.push_back(exp_byte(16'h0200));
        serve_burst(15'h0100, 2);
        observe("mv_fill", 1);

        // invalidate during DATA: fill completes, line stays invalid, refetch
        tick();
        rom_addr = 16'h0100;
        tick();
        sdram_gnt = 1'b1;
        tick();
        sdram_gnt = 1'b0; sdram_dst = 1'b1; sdram_din = memw(15'h0080); inv = 1'b1;
        tick();
        inv = 1'b0; sdram_din = memw(15'h0081);
        tick();
        sdram_dst = 1'b0;
        @(negedge clk);
        chk("invd_ok", 32'(rom_ok), 32'd0);
        sb.push_back(exp_byte(16'h0100));
        serve_burst(15'h0080, 0);
        observe("invd_refetch", 1);

        // top of address space
        tick();
        rom_addr = 16'hFFFF;
        sb.push_back(exp_byte(16'hFFFF));
        serve_burst(15'h7FFE, 0);
        observe("wrap_fill", 1);
        tick();
        rom_addr = 16'hFFFC;
        sb.push_back(exp_byte(16'hFFFC));
        observe("wrap_hit", 0);

        // reset while a request is pending
        tick();
        rom_addr = 16'h0400;
        tick();
        chk("mid_req_up", 32'(sdram_req), 32'd1);
        #2 rstn = 1'b0;
        #1 chk("mid_req_async", 32'(sdram_req), 32'd0);
        rom_cs = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        sdram_dst = 1'b1; sdram_din = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stray_ok", 32'(rom_ok), 32'd0);
            chk("stray_req", 32'(sdram_req), 32'd0);
        end
        sdram_dst = 1'b0;
        chk("stray_addr", 32'(sdram_addr), 32'd0);
        rom_cs = 1'b1; rom_addr = 16'h0102;
        #1 chk("cold_ok", 32'(rom_ok), 32'd0);
        sb.push_back(exp_byte(16'h0102));
        serve_burst(15'h0080, 0);
        observe("cold_fill", 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            rom_addr = hv[i];
            sb.push_back(exp_byte(hv[i]));
            observe("hit2", 0);
        end
        tick();
        rom_addr = 16'h0204;
        sb.push_back(exp_byte(16'h0204));
        serve_burst(15'h0102, 0);
        observe("fill2", 1);

`ifdef JTKIWI_ROMRSP_STATS_EN
        chk("stat_hits", 32'(hit_cnt), 32'd3);
        chk("stat_miss", 32'(miss_cnt), 32'd2);
        for (int i = 0; i < 70000; i++) begin
            tick();
            rom_addr[0] = ~rom_addr[0];
        end
        @(negedge clk);
        chk("stat_sat", 32'(hit_cnt), 32'hFFFF);
        chk("stat_miss_hold", 32'(miss_cnt), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
